mempool_dma_frontend: RTL and testbench



---
 rtl/mempool_pkg.sv | 25 ++
 rtl/mempool_dma_frontend.sv | 157 +++++++++++++++
 tb/tb_mempool_dma_frontend.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mempool_pkg.sv
// Shared MemPool cluster types: DMA request/status structs and the DMA front-end register map.
package mempool_pkg;

  localparam int unsigned DmaAddrWidth = 32;

  typedef struct packed {
    logic [DmaAddrWidth-1:0] src;
    logic [DmaAddrWidth-1:0] dst;
    logic [DmaAddrWidth-1:0] num_bytes;
  } dma_req_t;

  typedef struct packed {
    logic backend_idle;
    logic trans_complete;
  } dma_meta_t;

  localparam logic [7:0] DmaFrontSrcOff    = 8'h00;
  localparam logic [7:0] DmaFrontDstOff    = 8'h04;
  localparam logic [7:0] DmaFrontLenOff    = 8'h08;
  localparam logic [7:0] DmaFrontStatusOff = 8'h0C;
  localparam logic [7:0] DmaFrontNextIdOff = 8'h10;
  localparam logic [7:0] DmaFrontDoneOff   = 8'h14;
  localparam logic [7:0] DmaFrontPerfOff   = 8'h18;

endpackage

// File: rtl/mempool_dma_frontend.sv
// Register-mapped launch front end for the cluster DMA: programs src/dst/len, issues one burst per
// NEXT_ID read and tracks IDs/completions. Optional busy-cycle counter: MEMPOOL_DMA_FRONTEND_PERF_EN.
module mempool_dma_frontend
  import mempool_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned IdWidth        = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_write_i,
  input  logic [7:0]           cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_rvalid_o,
  output dma_req_t             dma_req_o,
  output logic                 dma_req_valid_o,
  input  logic                 dma_req_ready_i,
  input  dma_meta_t            dma_meta_i
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [0:0]           state_q;
  logic [AddrWidth-1:0] src_q, dst_q, len_q;
  logic [IdWidth-1:0]   next_id_q, done_cnt_q;
  logic [OutW-1:0]      outstanding_q;
  dma_req_t             req_q;
  logic                 rvalid_q;
  logic [AddrWidth-1:0] rdata_q, rd_val;
`ifdef MEMPOOL_DMA_FRONTEND_PERF_EN
  logic [31:0]          busy_cycles_q;
`endif

  logic is_launch, slots_full, accept, launch_go, launch_zero;
  logic handshake, complete, busy;

  // A launch is held off while every outstanding slot is in use; ISSUE blocks all accesses.
  assign is_launch   = !cfg_write_i && (cfg_addr_i == DmaFrontNextIdOff);
  assign slots_full  = (outstanding_q == OutW'(MaxOutstanding));
  assign accept      = cfg_valid_i && (state_q == StIdle) && !(is_launch && slots_full);
  assign launch_go   = accept && is_launch && (len_q != '0);
  assign launch_zero = accept && is_launch && (len_q == '0);
  assign handshake   = (state_q == StIssue) && dma_req_ready_i;
  assign complete    = dma_meta_i.trans_complete;
  assign busy        = (outstanding_q != '0) || (state_q != StIdle);

  assign cfg_ready_o     = accept;
  assign cfg_rvalid_o    = rvalid_q;
  assign cfg_rdata_o     = rdata_q;
  assign dma_req_o       = req_q;
  assign dma_req_valid_o = (state_q == StIssue);

  always_comb begin
    rd_val = '0;
    case (cfg_addr_i)
      DmaFrontSrcOff:    rd_val = src_q;
      DmaFrontDstOff:    rd_val = dst_q;
      DmaFrontLenOff:    rd_val = len_q;
      DmaFrontStatusOff: rd_val = AddrWidth'({dma_meta_i.backend_idle, busy});
      DmaFrontDoneOff:   rd_val = AddrWidth'(done_cnt_q);
`ifdef MEMPOOL_DMA_FRONTEND_PERF_EN
      DmaFrontPerfOff:   rd_val = AddrWidth'(busy_cycles_q);
`endif
      default:           rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (accept && cfg_write_i) begin
      case (cfg_addr_i)
        DmaFrontSrcOff: src_q <= cfg_wdata_i;
        DmaFrontDstOff: dst_q <= cfg_wdata_i;
        DmaFrontLenOff: len_q <= cfg_wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      req_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (launch_go) begin
            req_q   <= '{src: src_q, dst: dst_q, num_bytes: len_q};
            state_q <= StIssue;
          end
        end
        default: begin
          if (dma_req_ready_i) state_q <= StIdle;
        end
      endcase
    end
  end

  // The launch response is deferred until the cycle after the request handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (handshake || launch_zero) begin
        rvalid_q <= 1'b1;
        rdata_q  <= AddrWidth'(next_id_q);
      end else if (accept && !launch_go) begin
        rvalid_q <= 1'b1;
        rdata_q  <= cfg_write_i ? '0 : rd_val;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_id_q     <= '0;
      done_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      if (handshake || launch_zero) next_id_q <= next_id_q + IdWidth'(1);
      done_cnt_q <= done_cnt_q + IdWidth'(complete) + IdWidth'(launch_zero);
      if (handshake && !(complete && outstanding_q != '0)) begin
        outstanding_q <= outstanding_q + OutW'(1);
      end else if (!handshake && complete && outstanding_q != '0) begin
        outstanding_q <= outstanding_q - OutW'(1);
      end
    end
  end

`ifdef MEMPOOL_DMA_FRONTEND_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_cycles_q <= '0;
    end else if (accept && cfg_write_i && cfg_addr_i == DmaFrontPerfOff) begin
      busy_cycles_q <= '0;
    end else if (busy && busy_cycles_q != '1) begin
      busy_cycles_q <= busy_cycles_q + 32'd1;
    end
  end
`endif

  spurious_complete: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dma_meta_i.trans_complete |-> outstanding_q != '0);

endmodule

// File: tb/tb_mempool_dma_frontend.sv
// Scoreboard bench for mempool_dma_frontend: a register-level model predicts accepts, responses and
// DMA requests; a separate monitor compares whatever the DUT presents.
module tb_mempool_dma_frontend;
  import mempool_pkg::*;

  localparam int unsigned MaxOut = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic        cfg_write_i = 1'b0;
  logic [7:0]  cfg_addr_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        cfg_rvalid_o;
  dma_req_t    dma_req_o;
  logic        dma_req_valid_o;
  logic        dma_req_ready_i = 1'b0;
  dma_meta_t   dma_meta_i = '0;

  mempool_dma_frontend #(
    .AddrWidth(32),
    .MaxOutstanding(MaxOut),
    .IdWidth(32)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_write_i(cfg_write_i),
    .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o),
    .cfg_rvalid_o(cfg_rvalid_o),
    .dma_req_o(dma_req_o),
    .dma_req_valid_o(dma_req_valid_o),
    .dma_req_ready_i(dma_req_ready_i),
    .dma_meta_i(dma_meta_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          check_data;
    logic [31:0] data;
    logic [7:0]  addr;
  } rsp_t;

  rsp_t     rsp_q[$];
  dma_req_t req_q[$];
  int       checks = 0;
  int       fails = 0;

  // Software-visible model: programmed registers, ID/done counters, in-flight transfers.
  logic [31:0] m_src, m_dst, m_len, m_next_id, m_done;
  int          m_out;
  bit          m_pending;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_src = '0; m_dst = '0; m_len = '0; m_next_id = '0; m_done = '0;
    m_out = 0; m_pending = 1'b0;
    rsp_q.delete();
    req_q.delete();
  endtask

  // One bus cycle: drive at the falling edge, check handshake outputs, then advance the model.
  task automatic applyStimulus(input bit valid, input bit write, input logic [7:0] addr,
                               input logic [31:0] wdata, input bit rdy, input bit comp,
                               input bit bidle, output bit accepted);
    bit          comp_eff, is_launch, exp_ready, hs, busy_now;
    logic [31:0] val;
    @(negedge clk_i);
    comp_eff = comp && (m_out > 0);
    cfg_valid_i = valid;
    cfg_write_i = write;
    cfg_addr_i = addr;
    cfg_wdata_i = wdata;
    dma_req_ready_i = rdy;
    dma_meta_i.backend_idle = bidle;
    dma_meta_i.trans_complete = comp_eff;
    #1;
    is_launch = !write && addr == 8'h10;
    exp_ready = valid && !m_pending && !(is_launch && m_out == int'(MaxOut));
    checkOutput("cfg_ready", {31'd0, cfg_ready_o}, {31'd0, exp_ready});
    checkOutput("req_valid", {31'd0, dma_req_valid_o}, {31'd0, m_pending});
    accepted = exp_ready;
    hs = m_pending && rdy;
    busy_now = (m_out != 0) || m_pending;
    if (accepted) begin
      if (write) begin
        rsp_q.push_back('{check_data: 1'b0, data: 32'd0, addr: addr});
        case (addr)
          8'h00: m_src = wdata;
          8'h04: m_dst = wdata;
          8'h08: m_len = wdata;
          default: ;
        endcase
      end else if (is_launch) begin
        rsp_q.push_back('{check_data: 1'b1, data: m_next_id, addr: addr});
        if (m_len == 0) m_done = m_done + 1;
        else begin
          req_q.push_back('{src: m_src, dst: m_dst, num_bytes: m_len});
          m_pending = 1'b1;
        end
        m_next_id = m_next_id + 1;
      end else begin
        case (addr)
          8'h00: val = m_src;
          8'h04: val = m_dst;
          8'h08: val = m_len;
          8'h0C: val = {30'd0, bidle, busy_now};
          8'h14: val = m_done;
          default: val = 32'd0;
        endcase
        rsp_q.push_back('{check_data: 1'b1, data: val, addr: addr});
      end
    end
    if (comp_eff) m_done = m_done + 1;
    if (hs) m_pending = 1'b0;
    m_out = m_out + (hs ? 1 : 0) - (comp_eff ? 1 : 0);
  endtask

  task automatic cfgAccess(input bit write, input logic [7:0] addr, input logic [31:0] wdata, input bit rdy);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      applyStimulus(1'b1, write, addr, wdata, rdy, 1'b0, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("[TB] FAIL access_timeout: addr 0x%02h never accepted, required acceptance", addr);
    end
  endtask

  task automatic idle(input int cycles, input bit rdy, input bit comp);
    bit acc;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, rdy, comp, 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_out != 0 || m_pending) && n < 50) begin
      idle(1, 1'b1, 1'b1);
      n++;
    end
    idle(2, 1'b1, 1'b0);
  endtask

  // Monitor: request stability/contents while valid, response data on every rvalid.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni) begin
        if (dma_req_valid_o) begin
          if (req_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL dma_req_unexpected: valid high, required no request");
          end else begin
            checkOutput("dma_req_src", dma_req_o.src, req_q[0].src);
            checkOutput("dma_req_dst", dma_req_o.dst, req_q[0].dst);
            checkOutput("dma_req_len", dma_req_o.num_bytes, req_q[0].num_bytes);
            if (dma_req_ready_i) void'(req_q.pop_front());
          end
        end
        if (cfg_rvalid_o) begin
          if (rsp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL rvalid_unexpected: rvalid high, required no response");
          end else begin
            r = rsp_q.pop_front();
            if (r.check_data) checkOutput($sformatf("rdata_off_%02h", r.addr), cfg_rdata_o, r.data);
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    logic [7:0] addrs [8];
    logic [7:0] a;
    bit w;
    logic [31:0] wd;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    modelReset();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_rvalid", {31'd0, cfg_rvalid_o}, 32'd0);
    checkOutput("reset_rdata", cfg_rdata_o, 32'd0);
    checkOutput("reset_req_valid", {31'd0, dma_req_valid_o}, 32'd0);
    checkOutput("reset_ready", {31'd0, cfg_ready_o}, 32'd0);
    checkOutput("reset_req_src", dma_req_o.src, 32'd0);
    checkOutput("reset_req_len", dma_req_o.num_bytes, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] basic launches");
    cfgAccess(1'b1, 8'h00, 32'h8000_0000, 1'b1);
    cfgAccess(1'b1, 8'h04, 32'h0000_1000, 1'b1);
    cfgAccess(1'b1, 8'h08, 32'h0000_0400, 1'b1);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    idle(1, 1'b1, 1'b0);

    $display("[TB] outstanding limit");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h10, 32'd0, 1'b1, 1'b0, 1'b0, acc);
    cfgAccess(1'b0, 8'h0C, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'd0, 1'b1, 1'b1, 1'b0, acc);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h0C, 32'd0, 1'b1);
    drain();

    $display("[TB] ready held low");
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'h00, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, acc);
    cfgAccess(1'b1, 8'h00, 32'hDEAD_BEEF, 1'b1);
    cfgAccess(1'b0, 8'h00, 32'd0, 1'b1);
    drain();

    $display("[TB] completion coincident with handshake");
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    idle(1, 1'b1, 1'b0);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b0);
    idle(1, 1'b1, 1'b1);
    cfgAccess(1'b0, 8'h14, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h0C, 32'd0, 1'b1);
    drain();

    $display("[TB] zero length and unmapped offsets");
    cfgAccess(1'b1, 8'h08, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h14, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h18, 32'd0, 1'b1);
    cfgAccess(1'b1, 8'h1C, 32'h1234_5678, 1'b1);
    cfgAccess(1'b0, 8'h1C, 32'd0, 1'b1);
    idle(2, 1'b1, 1'b0);

    $display("[TB] id wrap");
    cfgAccess(1'b1, 8'h08, 32'h0000_0040, 1'b1);
    idle(1, 1'b1, 1'b0);
    #1;
    force dut.next_id_q = 32'hFFFF_FFFF;
    #1;
    release dut.next_id_q;
    m_next_id = 32'hFFFF_FFFF;
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      a = addrs[$urandom_range(0, 7)];
      w = ($urandom_range(0, 9) < 4);
      wd = $urandom();
      if (a == 8'h08 && $urandom_range(0, 3) == 0) wd = 32'd0;
      applyStimulus($urandom_range(0, 3) != 0, w, a, wd, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), acc);
    end
    drain();

    $display("[TB] reset during issue");
    cfgAccess(1'b1, 8'h08, 32'h0000_0100, 1'b1);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b0);
    idle(1, 1'b0, 1'b0);
    @(negedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("reset_async_req_valid", {31'd0, dma_req_valid_o}, 32'd0);
    modelReset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cfgAccess(1'b0, 8'h14, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h00, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h0C, 32'd0, 1'b1);
    cfgAccess(1'b0, 8'h10, 32'd0, 1'b1);
    idle(3, 1'b1, 1'b0);

    checkOutput("rsp_queue_empty", rsp_q.size(), 32'd0);
    checkOutput("req_queue_empty", req_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
